// File: rtl/ss_pkg.sv
// ss_pkg: shared 7-segment constants and pattern-to-ASCII decode
// Used by ss_capture and by display-driver benches.
package ss_pkg;
  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;
  localparam int N_DIG = 4;
  function automatic logic [7:0] seg_to_ascii(input logic [6:0] s);
    case (s)
      7'h3F: return 8'h30;
      7'h06: return 8'h31;
      7'h5B: return 8'h32;
      7'h4F: return 8'h33;
      7'h66: return 8'h34;
      7'h6D: return 8'h35;
      7'h7D: return 8'h36;
      7'h07: return 8'h37;
      7'h7F: return 8'h38;
      7'h6F: return 8'h39;
      7'h77: return 8'h41;
      7'h7C: return 8'h62;
      7'h39: return 8'h43;
      7'h5E: return 8'h64;
      7'h79: return 8'h45;
      7'h71: return 8'h46;
      7'h76: return 8'h48;
      7'h38: return 8'h4C;
      7'h73: return 8'h50;
      7'h3E: return 8'h55;
      7'h40: return 8'h2D;
      7'h00: return 8'h20;
      default: return 8'h3F;
    endcase
  endfunction
endpackage

// File: rtl/ss_capture_filter.sv
// ss_stable_filter: input register plus run-length stability filter
// Ports: d (raw pins), q (registered value), acc (high in the cycle the run
// length reaches STABLE_CYCLES; the consumer commits on the following edge).
module ss_stable_filter #(
  parameter int W = 11,
  parameter int STABLE_CYCLES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic         acc
);
  localparam logic [7:0] SC = 8'(STABLE_CYCLES);
  logic [W-1:0] in_q, prev_q;
  logic [7:0] cnt_q, cnt_d;
  always_comb begin
    cnt_d = (in_q != prev_q) ? 8'd1 : (cnt_q == SC ? cnt_q : cnt_q + 8'd1);
    acc = (cnt_d == SC) && (cnt_q != SC);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      in_q <= '0;
      prev_q <= '0;
      cnt_q <= '0;
    end else begin
      in_q <= d;
      prev_q <= in_q;
      cnt_q <= cnt_d;
    end
  end
  assign q = in_q;
endmodule

// File: rtl/ss_capture.sv
// ss_capture: rebuilds the 4-digit frame shown on a multiplexed 7-segment bus
// Ports: ss/dig pins in; seg_out/ascii_out frame out; frame_valid and changed
// strobes; stalled level; err_multi pulse on a stable multi-bit dig.
module ss_capture
  import ss_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int TIMEOUT = 1023,
  parameter int SEG_ACTIVE_LOW = 0,
  parameter int DIG_ACTIVE_LOW = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  ss,
  input  logic [4:1]  dig,
  output logic [27:0] seg_out,
  output logic [31:0] ascii_out,
  output logic        frame_valid,
  output logic        changed,
  output logic        stalled,
  output logic        err_multi
);
  localparam logic [3:0] DIG_INV = (DIG_ACTIVE_LOW != 0) ? 4'hF : 4'h0;
  localparam logic [6:0] SEG_INV = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic [15:0] TO = 16'(TIMEOUT);
  logic [10:0] pin_r;
  logic acc, one_hot, multi, done, timeout_hit;
  logic [3:0] dig_r;
  logic [6:0] ss_r;
  logic [N_DIG-1:0][6:0] buf_q, buf_d;
  logic [N_DIG-1:0][7:0] ascii_q, ascii_d;
  logic [27:0] seg_q, seg_d;
  logic [3:0] seen_q, seen_d;
  logic [15:0] tcnt_q, tcnt_d;
  logic fv_q, fv_d, chg_q, chg_d, stall_q, stall_d, err_q, err_d;
  ss_stable_filter #(.W(11), .STABLE_CYCLES(STABLE_CYCLES)) u_filt (
    .clk(clk), .rst_n(rst_n), .d({dig, ss}), .q(pin_r), .acc(acc)
  );
  always_comb begin
    dig_r = pin_r[10:7] ^ DIG_INV;
    ss_r = pin_r[6:0] ^ SEG_INV;
    one_hot = acc && (dig_r != 4'd0) && ((dig_r & (dig_r - 4'd1)) == 4'd0);
    multi = acc && ((dig_r & (dig_r - 4'd1)) != 4'd0);
    done = seen_q == 4'hF;
    tcnt_d = one_hot ? 16'd0 : (tcnt_q == 16'hFFFF ? tcnt_q : tcnt_q + 16'd1);
    timeout_hit = tcnt_d == TO;
    stall_d = one_hot ? 1'b0 : (timeout_hit ? 1'b1 : stall_q);
    // clear first so a digit accepted in the completion cycle opens the next frame
    seen_d = ((done || timeout_hit) ? 4'h0 : seen_q) | (one_hot ? dig_r : 4'h0);
    for (int k = 0; k < N_DIG; k++) begin
      buf_d[k] = (one_hot && dig_r[k]) ? ss_r : buf_q[k];
      ascii_d[k] = done ? seg_to_ascii(buf_q[k]) : ascii_q[k];
    end
    seg_d = done ? buf_q : seg_q;
    fv_d = done;
    chg_d = done && (buf_q != seg_q);
    err_d = multi;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      buf_q <= '0;
      ascii_q <= {N_DIG{8'h20}};
      seg_q <= '0;
      seen_q <= '0;
      tcnt_q <= '0;
      fv_q <= 1'b0;
      chg_q <= 1'b0;
      stall_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      buf_q <= buf_d;
      ascii_q <= ascii_d;
      seg_q <= seg_d;
      seen_q <= seen_d;
      tcnt_q <= tcnt_d;
      fv_q <= fv_d;
      chg_q <= chg_d;
      stall_q <= stall_d;
      err_q <= err_d;
    end
  end
  assign seg_out = seg_q;
  assign ascii_out = ascii_q;
  assign frame_valid = fv_q;
  assign changed = chg_q;
  assign stalled = stall_q;
  assign err_multi = err_q;
endmodule

// File: tb/tb_ss_capture.sv
// tb_ss_capture: scoreboard bench for ss_capture (STABLE_CYCLES=4, TIMEOUT=50)
module tb_ss_capture;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [6:0] ss = '0;
  logic [4:1] dig = '0;
  logic [27:0] seg_out;
  logic [31:0] ascii_out;
  logic frame_valid, changed, stalled, err_multi;
  int tests_run = 0;
  int fails = 0;
  int err_cnt = 0;
  logic [27:0] last_seg = '0;
  typedef struct {
    logic [27:0] seg;
    logic [31:0] asc;
    logic        chg;
  } exp_t;
  exp_t exp_q[$];

  ss_capture #(.STABLE_CYCLES(4), .TIMEOUT(50)) dut (
    .clk(clk), .rst_n(rst_n), .ss(ss), .dig(dig), .seg_out(seg_out),
    .ascii_out(ascii_out), .frame_valid(frame_valid), .changed(changed),
    .stalled(stalled), .err_multi(err_multi)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n) begin
      if (err_multi) err_cnt++;
      if (changed && !frame_valid) begin
        tests_run++;
        fails++;
        $display("FAIL changed_without_frame: changed=1 frame_valid=0");
      end
      if (frame_valid) begin
        tests_run++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_frame: got seg=%h ascii=%h, none expected", seg_out, ascii_out);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (seg_out !== e.seg || ascii_out !== e.asc || changed !== e.chg) begin
            fails++;
            $display("FAIL frame: got seg=%h ascii=%h chg=%b, want seg=%h ascii=%h chg=%b",
                     seg_out, ascii_out, changed, e.seg, e.asc, e.chg);
          end
        end
      end
    end
  end

  task automatic push(input logic [6:0] d4, d3, d2, d1, input logic [31:0] asc);
    exp_t e;
    e.seg = {d4, d3, d2, d1};
    e.asc = asc;
    e.chg = (e.seg != last_seg);
    last_seg = e.seg;
    exp_q.push_back(e);
  endtask

  task automatic drive(input logic [3:0] d, input logic [6:0] s, input int n);
    dig = d;
    ss = s;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if (seg_out !== 28'h0 || ascii_out !== 32'h20202020) begin
      fails++;
      $display("FAIL reset_data: seg=%h ascii=%h want 0/20202020", seg_out, ascii_out);
    end
    tests_run++;
    if ({frame_valid, changed, stalled, err_multi} !== 4'b0) begin
      fails++;
      $display("FAIL reset_flags: fv/chg/stl/err=%b want 0000", {frame_valid, changed, stalled, err_multi});
    end
    rst_n = 1'b1;
  endtask

  task automatic test_frame;
    push(7'h38, 7'h38, 7'h79, 7'h76, 32'h4C4C4548);
    drive(4'b0001, 7'h76, 10);
    drive(4'b0010, 7'h79, 10);
    drive(4'b0100, 7'h38, 10);
    drive(4'b1000, 7'h38, 10);
    tests_run++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL frame_missing: %0d pending want 0", exp_q.size());
    end
    tests_run++;
    if (seg_out !== {7'h38, 7'h38, 7'h79, 7'h76}) begin
      fails++;
      $display("FAIL frame_hold: seg=%h want %h", seg_out, {7'h38, 7'h38, 7'h79, 7'h76});
    end
  endtask

  task automatic test_repeat;
    push(7'h38, 7'h38, 7'h79, 7'h76, 32'h4C4C4548);
    drive(4'b0001, 7'h76, 10);
    drive(4'b0010, 7'h79, 10);
    drive(4'b0100, 7'h38, 10);
    drive(4'b1000, 7'h38, 10);
    tests_run++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL repeat_missing: %0d pending want 0", exp_q.size());
    end
  endtask

  task automatic test_glitch;
    drive(4'b0000, 7'h00, 70);
    push(7'h07, 7'h6D, 7'h7D, 7'h5B, 32'h37353632);
    drive(4'b0001, 7'h06, 3);
    drive(4'b0001, 7'h5B, 10);
    drive(4'b0010, 7'h7D, 10);
    drive(4'b0100, 7'h6D, 10);
    drive(4'b1000, 7'h07, 10);
    tests_run++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL glitch_missing: %0d pending want 0", exp_q.size());
    end
  endtask

  task automatic test_multi;
    int e0;
    drive(4'b0000, 7'h00, 70);
    push(7'h4F, 7'h5B, 7'h06, 7'h3F, 32'h33323130);
    drive(4'b0001, 7'h3F, 10);
    drive(4'b0010, 7'h06, 10);
    e0 = err_cnt;
    drive(4'b0011, 7'h7F, 10);
    tests_run++;
    if (err_cnt - e0 != 1) begin
      fails++;
      $display("FAIL err_multi_cycles: %0d high cycles want 1", err_cnt - e0);
    end
    e0 = err_cnt;
    drive(4'b0100, 7'h5B, 10);
    drive(4'b1000, 7'h4F, 10);
    tests_run++;
    if (err_cnt != e0) begin
      fails++;
      $display("FAIL err_spurious: %0d extra cycles want 0", err_cnt - e0);
    end
    tests_run++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL multi_frame_missing: %0d pending want 0", exp_q.size());
    end
  endtask

  task automatic test_timeout;
    drive(4'b0000, 7'h00, 70);
    tests_run++;
    if (stalled !== 1'b1) begin
      fails++;
      $display("FAIL stall_idle: stalled=%b want 1", stalled);
    end
    drive(4'b0001, 7'h3F, 10);
    tests_run++;
    if (stalled !== 1'b0) begin
      fails++;
      $display("FAIL stall_clear: stalled=%b want 0", stalled);
    end
    // digit 2 reaches the pins at the next edge and is accepted 4 edges later
    drive(4'b0010, 7'h06, 10);
    drive(4'b0000, 7'h00, 44);
    tests_run++;
    if (stalled !== 1'b0) begin
      fails++;
      $display("FAIL stall_early: stalled=%b want 0 at 49 cycles", stalled);
    end
    drive(4'b0000, 7'h00, 1);
    tests_run++;
    if (stalled !== 1'b1) begin
      fails++;
      $display("FAIL stall_late: stalled=%b want 1 at 50 cycles", stalled);
    end
    drive(4'b0100, 7'h01, 10);
    tests_run++;
    if (stalled !== 1'b0) begin
      fails++;
      $display("FAIL stall_reclear: stalled=%b want 0", stalled);
    end
    drive(4'b1000, 7'h77, 10);
    push(7'h77, 7'h01, 7'h00, 7'h40, 32'h413F202D);
    drive(4'b0001, 7'h40, 10);
    drive(4'b0010, 7'h00, 10);
    tests_run++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL timeout_frame_missing: %0d pending want 0", exp_q.size());
    end
  endtask

  task automatic test_mid_reset;
    drive(4'b0000, 7'h00, 70);
    drive(4'b0001, 7'h6F, 10);
    drive(4'b0010, 7'h66, 10);
    drive(4'b0100, 7'h7C, 10);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    last_seg = '0;
    tests_run++;
    if (ascii_out !== 32'h20202020 || seg_out !== 28'h0) begin
      fails++;
      $display("FAIL mid_reset_out: ascii=%h seg=%h want 20202020/0", ascii_out, seg_out);
    end
    drive(4'b1000, 7'h71, 10);
    drive(4'b0000, 7'h00, 20);
    tests_run++;
    if (exp_q.size() != 0 || ascii_out !== 32'h20202020) begin
      fails++;
      $display("FAIL mid_reset_noframe: pending=%0d ascii=%h want 0/20202020", exp_q.size(), ascii_out);
    end
  endtask

  initial begin
    test_reset;
    test_frame;
    test_repeat;
    test_glitch;
    test_multi;
    test_timeout;
    test_mid_reset;
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end
endmodule
